// File: rtl/axi4_wr_ordered_intc_m2s.sv
// AXI4 write interconnect, NUM upstream ports to one master, W kept in AW order.
// Optional per-port burst tracking is enabled by AXI4_WR_INTC_TRACK_EN.
module axi4_wr_ordered_intc_m2s #(
    parameter int  NUM         = 8,
    parameter int  LAZISE      = 2,
    parameter int  ASIZE       = 32,
    parameter int  LSIZE       = 8,
    parameter int  DSIZE       = 256,
    parameter int  ORDER_DEPTH = 8,
    localparam int NSIZE       = $clog2(NUM)
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic [NUM-1:0]            s_awvalid,
    output logic [NUM-1:0]            s_awready,
    input  logic [NUM*ASIZE-1:0]      s_awaddr,
    input  logic [NUM*LSIZE-1:0]      s_awlen,
    input  logic [NUM*LAZISE-1:0]     s_awid,
    input  logic [NUM-1:0]            s_wvalid,
    output logic [NUM-1:0]            s_wready,
    input  logic [NUM*DSIZE-1:0]      s_wdata,
    input  logic [NUM-1:0]            s_wlast,
    output logic [NUM-1:0]            s_bvalid,
    input  logic [NUM-1:0]            s_bready,
    output logic [NUM*LAZISE-1:0]     s_bid,
    output logic [NUM*2-1:0]          s_bresp,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ASIZE-1:0]          m_awaddr,
    output logic [LSIZE-1:0]          m_awlen,
    output logic [LAZISE+NSIZE-1:0]   m_awid,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    output logic [DSIZE-1:0]          m_wdata,
    output logic                      m_wlast,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    input  logic [LAZISE+NSIZE-1:0]   m_bid,
    input  logic [1:0]                m_bresp,
    output logic                      bid_err,
    output logic [NUM*4-1:0]          wr_record
);

    localparam int MIDW = LAZISE + NSIZE;
    localparam int PW   = $clog2(ORDER_DEPTH);
    localparam int CW   = PW + 1;

    logic [NSIZE-1:0]   rr_q, rr_d;
    logic [2*NUM-1:0]   req_dbl;
    logic [NSIZE-1:0]   grant;
    logic               grant_vld;
    logic               aw_take;
    logic               aw_hs;

    logic               aw_valid_q, aw_valid_d;
    logic [ASIZE-1:0]   aw_addr_q, aw_addr_d;
    logic [LSIZE-1:0]   aw_len_q, aw_len_d;
    logic [MIDW-1:0]    aw_id_q, aw_id_d;
    logic [ASIZE-1:0]   sel_addr;
    logic [LSIZE-1:0]   sel_len;
    logic [LAZISE-1:0]  sel_id;

    logic [NSIZE-1:0]   ord_q [ORDER_DEPTH];
    logic [NSIZE-1:0]   ord_d [ORDER_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ord_empty;
    logic               ord_full;
    logic [NSIZE-1:0]   head;
    logic               w_pop;

    logic [NSIZE-1:0]   bport;
    logic               b_in_range;
    logic               bid_err_q, bid_err_d;

    assign ord_empty = (cnt_q == '0);
    assign ord_full  = (cnt_q == CW'(ORDER_DEPTH));
    assign head      = ord_q[rd_ptr_q];
    assign aw_take   = (!aw_valid_q || m_awready) && !ord_full;
    assign aw_hs     = aw_take && grant_vld;

    assign m_awvalid = aw_valid_q;
    assign m_awaddr  = aw_addr_q;
    assign m_awlen   = aw_len_q;
    assign m_awid    = aw_id_q;
    assign bid_err   = bid_err_q;

    // Round-robin pick: first requester at or after rr_q, wrapping.
    always_comb begin
        int off;
        int sum;
        off     = 0;
        req_dbl = {s_awvalid, s_awvalid} >> rr_q;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (req_dbl[i]) off = i;
        end
        sum = int'(rr_q) + off;
        if (sum >= NUM) sum = sum - NUM;
        grant     = NSIZE'(sum);
        grant_vld = |s_awvalid;
    end

    // Next search start is the port after the one just granted.
    always_comb begin
        rr_d = rr_q;
        if (aw_hs) begin
            if (grant == NSIZE'(NUM - 1)) rr_d = '0;
            else                          rr_d = grant + NSIZE'(1);
        end
    end

    // Mux the granted lane and raise its s_awready.
    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_id    = '0;
        s_awready = '0;
        for (int k = 0; k < NUM; k++) begin
            if (grant == NSIZE'(k)) begin
                sel_addr     = s_awaddr[k*ASIZE +: ASIZE];
                sel_len      = s_awlen[k*LSIZE +: LSIZE];
                sel_id       = s_awid[k*LAZISE +: LAZISE];
                s_awready[k] = aw_hs;
            end
        end
    end

    // AW output register: load on accept, hold while stalled.
    always_comb begin
        aw_valid_d = aw_valid_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_id_d    = aw_id_q;
        if (aw_valid_q && m_awready) aw_valid_d = 1'b0;
        if (aw_hs) begin
            aw_valid_d = 1'b1;
            aw_addr_d  = sel_addr;
            aw_len_d   = sel_len;
            aw_id_d    = {sel_id, grant};
        end
    end

    // W steering from the order FIFO head port.
    always_comb begin
        m_wvalid = 1'b0;
        m_wdata  = '0;
        m_wlast  = 1'b0;
        s_wready = '0;
        for (int k = 0; k < NUM; k++) begin
            if (!ord_empty && head == NSIZE'(k)) begin
                m_wvalid    = s_wvalid[k];
                m_wdata     = s_wdata[k*DSIZE +: DSIZE];
                m_wlast     = s_wlast[k];
                s_wready[k] = m_wready;
            end
        end
    end

    assign w_pop = m_wvalid && m_wready && m_wlast;

    // Order FIFO: push granted port on AW accept, pop on last W beat.
    always_comb begin
        ord_d    = ord_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (aw_hs) begin
            ord_d[wr_ptr_q] = grant;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (w_pop) rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({aw_hs, w_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // B steering by the port index carried in the low ID bits.
    always_comb begin
        bport      = m_bid[NSIZE-1:0];
        b_in_range = 1'b0;
        m_bready   = 1'b1;
        s_bvalid   = '0;
        s_bid      = '0;
        s_bresp    = '0;
        for (int k = 0; k < NUM; k++) begin
            if (bport == NSIZE'(k)) begin
                b_in_range                 = 1'b1;
                s_bvalid[k]                = m_bvalid;
                m_bready                   = s_bready[k];
                s_bid[k*LAZISE +: LAZISE]  = m_bid[MIDW-1:NSIZE];
                s_bresp[k*2 +: 2]          = m_bresp;
            end
        end
        bid_err_d = bid_err_q || (m_bvalid && !b_in_range);
    end

    // State registers.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rr_q       <= '0;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_id_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            bid_err_q  <= 1'b0;
            for (int i = 0; i < ORDER_DEPTH; i++) ord_q[i] <= '0;
        end else begin
            rr_q       <= rr_d;
            aw_valid_q <= aw_valid_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_id_q    <= aw_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            bid_err_q  <= bid_err_d;
            for (int i = 0; i < ORDER_DEPTH; i++) ord_q[i] <= ord_d[i];
        end
    end

`ifdef AXI4_WR_INTC_TRACK_EN
    logic [3:0] rec_q [NUM];
    logic [3:0] rec_d [NUM];

    // Per-port outstanding count: +1 on AW accept, -1 on B accept.
    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            rec_d[k] = rec_q[k];
            if (s_awready[k] && !(s_bvalid[k] && s_bready[k]))
                rec_d[k] = rec_q[k] + 4'd1;
            else if (!s_awready[k] && s_bvalid[k] && s_bready[k])
                rec_d[k] = rec_q[k] - 4'd1;
        end
    end

    // Outstanding counters.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            for (int k = 0; k < NUM; k++) rec_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM; k++) rec_q[k] <= rec_d[k];
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        wr_record = '0;
        for (int k = 0; k < NUM; k++) wr_record[k*4 +: 4] = rec_q[k];
    end
`else
    assign wr_record = '0;
`endif

endmodule

// File: tb/tb_axi4_wr_ordered_intc_m2s.sv
// Bench for axi4_wr_ordered_intc_m2s: queue model plus directed scenarios.
// A second NUM=3 instance exercises out-of-range B routing.
module tb_axi4_wr_ordered_intc_m2s;

    localparam int N   = 4;
    localparam int L   = 2;
    localparam int A   = 32;
    localparam int LS  = 8;
    localparam int D   = 32;
    localparam int DEP = 8;
    localparam int NS  = 2;
    localparam int MW  = L + NS;
`ifdef AXI4_WR_INTC_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    s_awvalid, s_awready;
    logic [N*A-1:0]  s_awaddr;
    logic [N*LS-1:0] s_awlen;
    logic [N*L-1:0]  s_awid;
    logic [N-1:0]    s_wvalid, s_wready, s_wlast;
    logic [N*D-1:0]  s_wdata;
    logic [N-1:0]    s_bvalid, s_bready;
    logic [N*L-1:0]  s_bid;
    logic [N*2-1:0]  s_bresp;
    logic            m_awvalid, m_awready;
    logic [A-1:0]    m_awaddr;
    logic [LS-1:0]   m_awlen;
    logic [MW-1:0]   m_awid;
    logic            m_wvalid, m_wready, m_wlast;
    logic [D-1:0]    m_wdata;
    logic            m_bvalid, m_bready;
    logic [MW-1:0]   m_bid;
    logic [1:0]      m_bresp;
    logic            bid_err;
    logic [N*4-1:0]  wr_record;

    logic [2:0]  t_awready, t_wready, t_sbvalid, t_bready;
    logic [5:0]  t_sbid, t_sbresp;
    logic        t_mawvalid, t_mwvalid, t_mwlast, t_bvalid, t_mbready, t_biderr;
    logic [31:0] t_mawaddr, t_mwdata;
    logic [7:0]  t_mawlen;
    logic [3:0]  t_mawid, t_bid;
    logic [11:0] t_wrrec;

    axi4_wr_ordered_intc_m2s #(
        .NUM(N), .LAZISE(L), .ASIZE(A), .LSIZE(LS), .DSIZE(D), .ORDER_DEPTH(DEP)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awid(s_awid),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awid(m_awid),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .bid_err(bid_err), .wr_record(wr_record)
    );

    axi4_wr_ordered_intc_m2s #(
        .NUM(3), .LAZISE(2), .ASIZE(32), .LSIZE(8), .DSIZE(32), .ORDER_DEPTH(8)
    ) dut3 (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s_awvalid(3'b000), .s_awready(t_awready), .s_awaddr(96'd0),
        .s_awlen(24'd0), .s_awid(6'd0),
        .s_wvalid(3'b000), .s_wready(t_wready), .s_wdata(96'd0), .s_wlast(3'b000),
        .s_bvalid(t_sbvalid), .s_bready(t_bready), .s_bid(t_sbid), .s_bresp(t_sbresp),
        .m_awvalid(t_mawvalid), .m_awready(1'b1), .m_awaddr(t_mawaddr),
        .m_awlen(t_mawlen), .m_awid(t_mawid),
        .m_wvalid(t_mwvalid), .m_wready(1'b1), .m_wdata(t_mwdata), .m_wlast(t_mwlast),
        .m_bvalid(t_bvalid), .m_bready(t_mbready), .m_bid(t_bid), .m_bresp(2'b01),
        .bid_err(t_biderr), .wr_record(t_wrrec)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int dut_acc = 0;

    int            mrr;
    bit            mov;
    logic [A-1:0]  moa;
    logic [LS-1:0] mol;
    logic [MW-1:0] moi;
    int            ordq[$];
    logic [3:0]    mrec [N];

    logic [MW-1:0] aw_log[$];
    int            aw_cyc[$];
    logic [D-1:0]  w_log[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Model: arbitration by RR order, AW register, order queue, B routing.
    task automatic model_step();
        int g, h, p;
        bit can, exp_wv, pop;
        logic [N-1:0] exp_awr, exp_wr, exp_bv;
        if (!rst_n) begin
            check("rst_m_awvalid", m_awvalid, 0);
            check("rst_m_wvalid", m_wvalid, 0);
            check("rst_s_wready", s_wready, 0);
            check("rst_bid_err", bid_err, 0);
            check("rst_wr_record", wr_record, 0);
            mrr = 0;
            mov = 0;
            ordq.delete();
            for (int k = 0; k < N; k++) mrec[k] = 4'd0;
            return;
        end
        check("m_awvalid", m_awvalid, mov);
        if (mov) begin
            check("m_awaddr", m_awaddr, moa);
            check("m_awlen", m_awlen, mol);
            check("m_awid", m_awid, moi);
        end
        can = (!mov || m_awready) && (ordq.size() < DEP);
        g = -1;
        if (can) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (mrr + i) % N;
                if (g < 0 && s_awvalid[k]) g = k;
            end
        end
        exp_awr = '0;
        if (g >= 0) exp_awr[g] = 1'b1;
        check("s_awready", s_awready, exp_awr);
        exp_wv = 0;
        exp_wr = '0;
        h = 0;
        if (ordq.size() > 0) begin
            h = ordq[0];
            exp_wv = s_wvalid[h];
            exp_wr[h] = m_wready;
        end
        check("m_wvalid", m_wvalid, exp_wv);
        check("s_wready", s_wready, exp_wr);
        if (exp_wv) begin
            check("m_wdata", m_wdata, s_wdata[h*D +: D]);
            check("m_wlast", m_wlast, s_wlast[h]);
        end
        p = int'(m_bid[NS-1:0]);
        exp_bv = '0;
        exp_bv[p] = m_bvalid;
        check("s_bvalid", s_bvalid, exp_bv);
        check("m_bready", m_bready, s_bready[p]);
        if (m_bvalid) begin
            check("s_bid", s_bid[p*L +: L], m_bid[MW-1:NS]);
            check("s_bresp", s_bresp[p*2 +: 2], m_bresp);
        end
        check("bid_err", bid_err, 0);
        for (int k = 0; k < N; k++)
            check("wr_record", wr_record[k*4 +: 4], TRACK ? mrec[k] : 4'd0);
        if (m_awvalid && m_awready) begin
            aw_log.push_back(m_awid);
            aw_cyc.push_back(cyc);
        end
        if (m_wvalid && m_wready) w_log.push_back(m_wdata);
        if (|(s_awvalid & s_awready)) dut_acc++;
        pop = exp_wv && m_wready && s_wlast[h];
        if (mov && m_awready) mov = 0;
        if (g >= 0) begin
            mov = 1;
            moa = s_awaddr[g*A +: A];
            mol = s_awlen[g*LS +: LS];
            moi = {s_awid[g*L +: L], NS'(g)};
            ordq.push_back(g);
            mrr = (g + 1) % N;
            mrec[g] = mrec[g] + 4'd1;
        end
        if (pop) void'(ordq.pop_front());
        if (m_bvalid && s_bready[p]) mrec[p] = mrec[p] - 4'd1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) model_step();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awid = '0;
        s_wvalid = '0; s_wdata = '0; s_wlast = '0; s_bready = '0;
        m_awready = 1'b1; m_wready = 1'b1;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic aw_send(int k, logic [A-1:0] addr, logic [LS-1:0] len, logic [L-1:0] id);
        bit ok;
        ok = 0;
        s_awaddr[k*A +: A]   = addr;
        s_awlen[k*LS +: LS]  = len;
        s_awid[k*L +: L]     = id;
        s_awvalid[k]         = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_awready[k]) begin
                ok = 1;
                break;
            end
        end
        check("aw_handshake", ok, 1);
        @(posedge clk);
        #1;
        s_awvalid[k] = 1'b0;
    endtask

    task automatic w_send(int k, int nbeats);
        bit ok;
        for (int b = 0; b < nbeats; b++) begin
            ok = 0;
            s_wdata[k*D +: D] = D'(k * 256 + b);
            s_wlast[k]        = (b == nbeats - 1);
            s_wvalid[k]       = 1'b1;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (s_wready[k]) begin
                    ok = 1;
                    break;
                end
            end
            check("w_handshake", ok, 1);
            @(posedge clk);
            #1;
        end
        s_wvalid[k] = 1'b0;
        s_wlast[k]  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        t_bvalid = 1'b0;
        t_bid    = '0;
        t_bready = '0;
        step();
        step();
        rst_n = 1'b1;
        check("idle_m_awvalid", m_awvalid, 0);

        // Round-robin: ports 0,1,2 together, then 0 and 3 with a stall.
        aw_log.delete();
        aw_cyc.delete();
        fork
            aw_send(0, 32'h100, 8'd0, 2'd1);
            aw_send(1, 32'h110, 8'd0, 2'd1);
            aw_send(2, 32'h120, 8'd0, 2'd1);
        join
        step();
        step();
        check("rr_count", aw_log.size(), 3);
        check("rr_id0", aw_log[0], 4'h4);
        check("rr_id1", aw_log[1], 4'h5);
        check("rr_id2", aw_log[2], 4'h6);
        check("rr_gap01", aw_cyc[1] - aw_cyc[0], 1);
        check("rr_gap12", aw_cyc[2] - aw_cyc[1], 1);
        check("model_rr", mrr, 3);
        aw_log.delete();
        fork
            aw_send(0, 32'h200, 8'd0, 2'd1);
            aw_send(3, 32'h230, 8'd0, 2'd1);
            begin
                m_awready = 1'b0;
                step();
                step();
                step();
                m_awready = 1'b1;
            end
        join
        step();
        step();
        check("rr2_count", aw_log.size(), 2);
        check("rr2_first", aw_log[0], 4'h7);
        check("rr2_second", aw_log[1], 4'h4);

        // Reset with queued entries: no W routed afterwards.
        do_reset();
        s_wdata[D-1:0] = 32'hdead;
        s_wvalid[0] = 1'b1;
        @(negedge clk);
        check("post_rst_wvalid", m_wvalid, 0);
        check("post_rst_wready", s_wready, 0);
        step();
        s_wvalid[0] = 1'b0;

        // W ordering: port 2 burst of 4, then port 0 single beat.
        w_log.delete();
        fork
            begin
                aw_send(2, 32'h300, 8'd3, 2'd2);
                aw_send(0, 32'h400, 8'd0, 2'd3);
            end
            w_send(2, 4);
            w_send(0, 1);
        join
        step();
        check("w_count", w_log.size(), 5);
        check("w_beat0", w_log[0], 32'h200);
        check("w_beat1", w_log[1], 32'h201);
        check("w_beat2", w_log[2], 32'h202);
        check("w_beat3", w_log[3], 32'h203);
        check("w_beat4", w_log[4], 32'h000);
        check("model_empty", ordq.size(), 0);
        s_wvalid[1] = 1'b1;
        @(negedge clk);
        check("empty_wvalid", m_wvalid, 0);
        check("empty_wready", s_wready, 0);
        step();
        s_wvalid[1] = 1'b0;

        // Order FIFO full: 8 accepted, 9th waits for the first pop.
        do_reset();
        m_wready = 1'b0;
        dut_acc = 0;
        for (int i = 0; i < 8; i++)
            aw_send(i % 4, 32'h500 + 32'(i * 16), 8'd0, 2'd0);
        check("fifo_acc8", dut_acc, 8);
        fork
            aw_send(0, 32'h600, 8'd0, 2'd0);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("full_awready", s_awready, 0);
                end
                @(posedge clk);
                #1;
                m_wready = 1'b1;
                w_send(0, 1);
            end
        join
        check("fifo_acc9", dut_acc, 9);

        // B backpressure on port 1 for 3 cycles.
        do_reset();
        m_bid    = 4'b1101;
        m_bresp  = 2'b10;
        m_bvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b_wait_bvalid1", s_bvalid[1], 1);
            check("b_wait_bid1", s_bid[3:2], 2'd3);
            check("b_wait_mbready", m_bready, 0);
        end
        @(posedge clk);
        #1;
        s_bready[1] = 1'b1;
        @(negedge clk);
        check("b_hs_mbready", m_bready, 1);
        check("b_hs_bvalid1", s_bvalid[1], 1);
        step();
        m_bvalid = 1'b0;
        s_bready = '0;

        // NUM=3 instance: in-range then out-of-range B.
        check("t3_idle", {t_mawvalid, t_mwvalid, t_awready, t_wready}, 0);
        check("t3_init_err", t_biderr, 0);
        t_bid    = 4'b1001;
        t_bvalid = 1'b1;
        @(negedge clk);
        check("t3_in_mbready", t_mbready, 0);
        check("t3_in_sbvalid", t_sbvalid, 3'b010);
        check("t3_in_sbid", t_sbid[3:2], 2'b10);
        step();
        check("t3_in_err", t_biderr, 0);
        t_bid = 4'b0011;
        @(negedge clk);
        check("t3_out_mbready", t_mbready, 1);
        check("t3_out_sbvalid", t_sbvalid, 0);
        step();
        t_bvalid = 1'b0;
        step();
        step();
        step();
        check("t3_err_sticky", t_biderr, 1);
        do_reset();
        check("t3_err_cleared", t_biderr, 0);

        // Tracking: simultaneous AW and B on port 1 leaves count unchanged.
        aw_send(1, 32'h700, 8'd0, 2'd0);
        aw_send(1, 32'h710, 8'd0, 2'd0);
        step();
        check("rec_two", wr_record[7:4], TRACK ? 4'd2 : 4'd0);
        m_bid       = 4'b0001;
        m_bvalid    = 1'b1;
        s_bready[1] = 1'b1;
        fork
            aw_send(1, 32'h720, 8'd0, 2'd0);
            begin
                @(negedge clk);
                check("same_cycle_b", m_bready & s_bvalid[1], 1);
                check("same_cycle_aw", s_awready[1], 1);
                @(posedge clk);
                #1;
                m_bvalid = 1'b0;
                s_bready = '0;
            end
        join
        step();
        check("rec_same_cycle", wr_record[7:4], TRACK ? 4'd2 : 4'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_wr_ordered_intc_m2s.md
AXI4_WR_ORDERED_INTC_M2S -- requirements
Module: axi4_wr_ordered_intc_m2s

Interface
REQ-001 Parameters SHALL be, one per line:
  - NUM, 8, number of upstream write initiator ports.
  - LAZISE, 2, upstream ID width.
  - ASIZE, 32, address width.
  - LSIZE, 8, burst length width.
  - DSIZE, 256, data width.
  - ORDER_DEPTH, 8, entries in the W-order FIFO (power of 2).
  - NSIZE = $clog2(NUM) is local; master ID width = LAZISE+NSIZE.
REQ-002 Ports SHALL be, one per line (s_* vectors are NUM lanes packed, lane k at [k*W+:W]):
  - axi_aclk  in  1  single clock for all logic.
  - axi_aresetn  in  1  asynchronous active-low reset.
  - s_awvalid/s_awready  in/out  NUM  upstream AW handshake.
  - s_awaddr, s_awlen, s_awid  in  NUM*ASIZE, NUM*LSIZE, NUM*LAZISE  upstream AW payload.
  - s_wvalid/s_wready  in/out  NUM  upstream W handshake.
  - s_wdata, s_wlast  in  NUM*DSIZE, NUM  upstream W payload.
  - s_bvalid/s_bready  out/in  NUM  upstream B handshake.
  - s_bid, s_bresp  out  NUM*LAZISE, NUM*2  upstream B payload.
  - m_awvalid/m_awready  out/in  1  master AW handshake.
  - m_awaddr, m_awlen, m_awid  out  ASIZE, LSIZE, LAZISE+NSIZE  master AW payload.
  - m_wvalid/m_wready, m_wdata, m_wlast  out/in, out, out  1, DSIZE, 1  master W channel.
  - m_bvalid/m_bready, m_bid, m_bresp  in/out, in, in  1, LAZISE+NSIZE, 2  master B channel.
  - bid_err  out  1  sticky flag: B with out-of-range port index.
  - wr_record  out  NUM*4  per-port outstanding-burst count (see Configuration).

Function
REQ-003 AW arbitration SHALL be round-robin: search starts at last granted port +1, wrapping NUM-1 to 0.
REQ-004 AW SHALL pass through one output register stage: upstream handshake at cycle N gives m_awvalid at N+1.
REQ-005 Upstream AW handshake SHALL require: output stage empty or emptying (m_awready), and order FIFO not full.
REQ-006 m_awid SHALL be {s_awid[k], k[NSIZE-1:0]}; m_awaddr/m_awlen SHALL equal lane k unchanged.
REQ-007 While m_awvalid=1 and m_awready=0, all m_aw* SHALL remain stable.
REQ-008 Each upstream AW handshake SHALL push port index k into the order FIFO in the same cycle.
REQ-009 W routing SHALL be combinational from the FIFO head h:
  - m_wvalid = !empty & s_wvalid[h]; s_wready[h] = !empty & m_wready; all other s_wready = 0.
  - m_wdata/m_wlast = lane h.
REQ-010 Pop SHALL occur on the m_wvalid & m_wready & m_wlast cycle; beats without wlast do not pop.
REQ-011 Simultaneous push and pop SHALL leave the count unchanged; a push to a full FIFO SHALL be impossible by REQ-005.
REQ-012 Empty FIFO SHALL give m_wvalid=0 and all s_wready=0; W beats offered before their AW stall until that AW is pushed.
REQ-013 B routing SHALL be combinational on p = m_bid[NSIZE-1:0]:
  - s_bvalid[p] = m_bvalid; m_bready = s_bready[p].
  - s_bid[p] = m_bid[LAZISE+NSIZE-1:NSIZE]; s_bresp[p] = m_bresp.
REQ-014 If p >= NUM: m_bready SHALL be 1 (response discarded) and bid_err SHALL set and hold until reset.

Reset
REQ-015 On axi_aresetn low, asynchronously:
  - m_awvalid=0, order FIFO empty, round-robin pointer=0, bid_err=0, wr_record=0.
  - Consequently s_awready=0, s_wready=0, m_wvalid=0.
REQ-016 Reset mid-burst SHALL discard all queued order entries; no beat is routed after reset release until a new AW is accepted.

Configuration
REQ-017 Macro AXI4_WR_INTC_TRACK_EN selects per-port tracking:
  - Defined: wr_record[k] +1 on AW handshake of k, -1 on B handshake of k, unchanged if both occur in the same cycle; 4-bit wrap.
  - Undefined: wr_record SHALL be constant 0 and its counters SHALL not be synthesized.

Verification
REQ-018 NUM=4; ports 0,1,2 assert awvalid together, m_awready=1 -> m_awid low bits 0,1,2 on consecutive cycles; next round of requests starts at port 3.
REQ-019 Port 2 AW len=3 then port 0 AW len=0; both drive W -> master sees 4 beats of port 2 then 1 of port 0; FIFO empty afterwards.
REQ-020 ORDER_DEPTH=8, m_wready=0, 9 AWs offered -> exactly 8 accepted, s_awready=0 for the 9th until the first wlast pop.
REQ-021 m_bvalid with m_bid={2'b11,2'd1}, s_bready[1]=0 for 3 cycles -> s_bvalid[1]=1, s_bid[1]=3, m_bready=0 for 3 cycles, handshake on the 4th.
REQ-022 NUM=3, m_bid low bits=3 -> m_bready=1 and bid_err=1, which persists until axi_aresetn pulses low.
REQ-023 TRACK_EN defined; port 1 AW and B handshake in the same cycle with wr_record[1]=2 -> stays 2; undefined -> always 0.
